// File: rtl/byte_viewer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : byte_viewer                                                   |
// | Purpose  : Holds a 128-bit block; next/prev buttons step the shown byte. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module byte_viewer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] block_in,
  input  logic         btn_next,
  input  logic         btn_prev,
  output logic [7:0]   data_out,
  output logic [3:0]   index,
  output logic         valid
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]   w_raw;
  logic [1:0]   w_press;
  logic [127:0] r_block;
  logic [3:0]   r_index;
  logic         r_valid;
  logic [3:0]   w_sel;

  assign w_raw = {btn_prev, btn_next};

  // Bit 0 is the next button, bit 1 the prev button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             r_s1;
    logic             r_s2;
    logic             r_stb;
    logic             r_stb_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_stb   <= 1'b0;
        r_stb_q <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_raw[gi];
        r_s2    <= r_s1;
        r_stb_q <= r_stb;
        if (r_s2 != r_stb) begin
          if (r_cnt == c_cnt_max) begin
            r_stb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_press[gi] = r_stb & ~r_stb_q;
  end

  // A load wins over any press in the same cycle; simultaneous presses cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_block <= '0;
      r_index <= 4'd0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_block <= block_in;
      r_index <= 4'd0;
      r_valid <= 1'b1;
    end else if (w_press[0] && !w_press[1]) begin
      r_index <= r_index + 4'd1;
    end else if (w_press[1] && !w_press[0]) begin
      r_index <= r_index - 4'd1;
    end
  end

  // Index 0 is the most significant byte, so flip the index before scaling.
  assign w_sel    = ~r_index;
  assign data_out = r_block[{w_sel, 3'b000} +: 8];
  assign index    = r_index;
  assign valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_byte_viewer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_byte_viewer                                                |
// | Purpose  : Self-checking bench for byte_viewer (DEBOUNCE_CYCLES = 4).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_byte_viewer;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [127:0] block_in = '0;
  logic         btn_next = 1'b0;
  logic         btn_prev = 1'b0;
  logic [7:0]   data_out;
  logic [3:0]   index;
  logic         valid;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h5A69788796A5B4C3D2E1F00112233445;

  byte_viewer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .block_in(block_in),
    .btn_next(btn_next), .btn_prev(btn_prev),
    .data_out(data_out), .index(index), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int byte_of(input logic [127:0] b, input int k);
    logic [127:0] s;
    s = b >> (8 * (15 - k));
    return int'(s[7:0]);
  endfunction

  // A button level is accepted once the last D synchronized samples all differ from it.
  function automatic bit settle(input bit q[$], input bit st);
    if (q.size() < D) return st;
    foreach (q[i]) if (q[i] == st) return st;
    return !st;
  endfunction

  logic [127:0] m_blk = '0;
  int           m_idx = 0;
  bit           m_valid = 1'b0;
  bit           m_d1[2];
  bit           m_d2[2];
  bit           m_st[2];
  bit           m_st_q[2];
  bit           hq_n[$];
  bit           hq_p[$];

  always @(posedge clk or negedge rst) begin : model
    bit raw[2];
    bit pr[2];
    if (!rst) begin
      m_blk = '0; m_idx = 0; m_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_st[b] = 0; m_st_q[b] = 0;
      end
      hq_n.delete(); hq_p.delete();
    end else begin
      raw[0] = btn_next;
      raw[1] = btn_prev;
      for (int b = 0; b < 2; b++) pr[b] = m_st[b] && !m_st_q[b];
      for (int b = 0; b < 2; b++) m_st_q[b] = m_st[b];
      hq_n.push_back(m_d2[0]);
      hq_p.push_back(m_d2[1]);
      if (hq_n.size() > D) void'(hq_n.pop_front());
      if (hq_p.size() > D) void'(hq_p.pop_front());
      m_st[0] = settle(hq_n, m_st[0]);
      m_st[1] = settle(hq_p, m_st[1]);
      for (int b = 0; b < 2; b++) begin
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
      if (load) begin
        m_blk = block_in; m_idx = 0; m_valid = 1'b1;
      end else if (pr[0] && !pr[1]) begin
        m_idx = (m_idx + 1) % 16;
      end else if (pr[1] && !pr[0]) begin
        m_idx = (m_idx + 15) % 16;
      end
    end
  end

  always @(negedge clk) begin
    check("model_index", int'(index), m_idx);
    check("model_valid", int'(valid), int'(m_valid));
    check("model_data", int'(data_out), byte_of(m_blk, m_idx));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next = 1'b1; else btn_prev = 1'b1;
    cyc(8);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc(8);
  endtask

  // Holds btn_next for n cycles, reporting the first-change cycle and number of changes.
  task automatic hold_next(input int n, output int lat, output int steps);
    logic [3:0] prev;
    prev = index;
    lat = -1;
    steps = 0;
    btn_next = 1'b1;
    for (int k = 1; k <= n; k++) begin
      cyc(1);
      if (index != prev) begin
        steps++;
        if (lat < 0) lat = k;
        prev = index;
      end
    end
  endtask

  initial begin
    int lat;
    int steps;
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      btn_next = i[0];
      btn_prev = ~i[0];
      cyc(1);
    end
    check("rst_data", int'(data_out), 8'h00);
    check("rst_index", int'(index), 0);
    check("rst_valid", int'(valid), 0);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    rst = 1'b1;
    cyc(3);
    check("post_rst_index", int'(index), 0);
    check("post_rst_valid", int'(valid), 0);

    block_in = BLK_A;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_valid", int'(valid), 1);
    check("load_index", int'(index), 0);
    check("load_data", int'(data_out), 8'h00);
    for (int i = 0; i < 15; i++) press(0);
    check("fwd15_index", int'(index), 15);
    check("fwd15_data", int'(data_out), 8'hFF);
    press(0);
    check("fwd_wrap_index", int'(index), 0);
    check("fwd_wrap_data", int'(data_out), 8'h00);

    press(1);
    check("back_wrap_index", int'(index), 15);
    check("back_wrap_data", int'(data_out), 8'hFF);
    press(1);
    check("back2_index", int'(index), 14);
    check("back2_data", int'(data_out), 8'hEE);

    btn_next = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    cyc(10);
    check("glitch_index", int'(index), 14);

    hold_next(100, lat, steps);
    btn_next = 1'b0;
    cyc(10);
    check("hold_latency", lat, 7);
    check("hold_steps", steps, 1);
    check("hold_index", int'(index), 15);
    check("hold_data", int'(data_out), 8'hFF);

    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2) == 0;
      cyc(1);
    end
    btn_next = 1'b1;
    cyc(10);
    btn_next = 1'b0;
    cyc(10);
    check("bounce_index", int'(index), 0);
    check("bounce_data", int'(data_out), 8'h00);

    btn_next = 1'b1;
    btn_prev = 1'b1;
    cyc(20);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc(10);
    check("both_index", int'(index), 0);

    press(0);
    check("pre_load_index", int'(index), 1);
    check("pre_load_data", int'(data_out), 8'h11);
    btn_next = 1'b1;
    cyc(6);
    block_in = BLK_B;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_press_index", int'(index), 0);
    check("load_press_data", int'(data_out), 8'h5A);
    cyc(3);
    check("load_press_hold_index", int'(index), 0);
    btn_next = 1'b0;
    cyc(8);

    for (int i = 0; i < 7; i++) press(0);
    check("idx7_index", int'(index), 7);
    check("idx7_data", int'(data_out), 8'hC3);
    btn_next = 1'b1;
    cyc(2);
    rst = 1'b0;
    #1;
    check("midrst_index", int'(index), 0);
    check("midrst_valid", int'(valid), 0);
    cyc(3);
    rst = 1'b1;
    hold_next(20, lat, steps);
    btn_next = 1'b0;
    cyc(10);
    check("rst_hold_latency", lat, 7);
    check("rst_hold_steps", steps, 1);
    check("rst_hold_index", int'(index), 1);
    check("rst_hold_data", int'(data_out), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/byte_viewer.md
# byte_viewer

Upstream feeder for the two-digit seven-segment display driver. Captures a 128-bit AES result block on a one-cycle load pulse, then lets the operator step through its 16 bytes with two debounced pushbuttons (next/prev). Presents the selected byte as a stable 8-bit value for the display driver's `data_in`, along with the byte index and a valid flag.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive clock cycles a synchronized button level must differ from the debounced level before it is accepted. Default is 20 ms at 50 MHz. Minimum 2.
- `CNT_W`, default 20: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` input 1: system clock. All state is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `load` input 1: single-cycle capture strobe from the AES core.
- `block_in` input 128: result block, sampled when `load`=1.
- `btn_next` input 1: raw pushbutton, asynchronous, active-high. Steps the index forward.
- `btn_prev` input 1: raw pushbutton, asynchronous, active-high. Steps the index back.
- `data_out` output 8: selected byte, fed to the display driver `data_in`.
- `index` output 4: current byte index, 0..15.
- `valid` output 1: high once a block has been captured since reset.

## Operation

- **Synchronizer:** each button passes through a 2-flop synchronizer (`s1` to `s2`).
- **Debouncer:** one per button, with counter `cnt` and debounced level `stb`. On each edge:
  - If `s2` != `stb`:
    - if `cnt` == DEBOUNCE_CYCLES-1, then `stb` <= `s2` and `cnt` <= 0;
    - otherwise `cnt` <= `cnt`+1.
  - If `s2` == `stb`, then `cnt` <= 0.
  - A bounce or glitch shorter than DEBOUNCE_CYCLES cycles never changes `stb`.
- **Press pulse:** `press` = `stb` & ~`stb_q`, where `stb_q` is `stb` registered. This gives exactly one pulse per accepted press. Releases produce no action, and holding a button produces only one step.
- **Index update**, in priority order:
  1. `load`=1: `block_r` <= `block_in`, `index` <= 0, `valid` <= 1. Any press pulse in the same cycle is discarded.
  2. Both `press_next` and `press_prev` in the same cycle: `index` unchanged.
  3. `press_next` only: `index` <= `index`+1 mod 16, so 15 wraps to 0.
  4. `press_prev` only: `index` <= `index`-1 mod 16, so 0 wraps to 15.
- **Presses before any load:** the index still moves, and `data_out` reads 0x00 because `block_r` is reset to 0.
- **Byte order:** index k selects `block_r`[127-8k -: 8]. Index 0 is the MSB byte (AES state byte 0); index 15 is `block_r`[7:0].
- **`data_out`:** a combinational mux of the registered `block_r` and `index` only. It has no path from `block_in` or the buttons.
- **Reset values:** `block_r`=0, `index`=0, `valid`=0, `data_out`=0x00. Reset also clears all synchronizer flops, `stb`, `stb_q` and `cnt`.
- **Reset mid-debounce:** any partial count is lost. A button still held when `rst` deasserts must again be seen for DEBOUNCE_CYCLES cycles before it is accepted; it then produces one step.

## Timing

- **Load latency:** `load` sampled at edge E; `valid`, `index`=0 and the new `data_out` are visible after edge E.
- **Button latency:** raw button rises before edge N and is held.
  - `s2` goes high after edge N+1.
  - `stb` goes high after edge N+1+DEBOUNCE_CYCLES.
  - `index` and `data_out` change after edge N+2+DEBOUNCE_CYCLES.
- **Release:** same debounce latency, with no output effect.
- **Throughput:** at most one step per button per press/release cycle, so the minimum press-to-press spacing is about 2×DEBOUNCE_CYCLES cycles.
- **Glitch-free outputs:** `data_out` and `index` change only on clock edges, as required by the display's scan mux.

## Test plan

The bench uses DEBOUNCE_CYCLES=4.

1. **Reset:** hold `rst`=0 for 5 cycles while toggling the buttons → `data_out`=0x00, `index`=0, `valid`=0; release `rst` → outputs remain unchanged.
2. **Load and forward wrap:** pulse `load` with `block_in`=0x00112233445566778899AABBCCDDEEFF → after that edge `valid`=1, `index`=0, `data_out`=0x00. Then 15 clean `btn_next` presses → `index`=15, `data_out`=0xFF. One more press → `index`=0, `data_out`=0x00.
3. **Backward wrap:** from `index`=0, one `btn_prev` press → `index`=15, `data_out`=0xFF; a second press → `index`=14, `data_out`=0xEE.
4. **Debounce:**
   - a 3-cycle `btn_next` pulse → no change;
   - `btn_next` held for 100 cycles → exactly one step, landing exactly N+2+4 edges after assertion;
   - bouncing (toggling every 2 cycles for 20 cycles, then steady high) → exactly one step.
5. **Simultaneous events:**
   - `btn_next` and `btn_prev` asserted on the same cycle and held → `index` unchanged;
   - `load` on the same cycle as a `press_next` pulse → `index`=0 and the new block captured.
6. **Reset mid-operation:** at `index`=7 with `btn_next` held for 2 cycles, assert `rst` → `index`=0, `valid`=0. Deassert `rst` with the button still held → exactly one step, to `index`=1, after 2+4 cycles.
